// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port main memory between I-cache refill,
// D-cache refill and D-cache store. One memory strobe per transaction,
// one completion pulse back to the winning requester.
//
// Handshake: every request (i_ic_read_req, i_dc_read_req, i_dc_write_valid)
// is a level held until its one-cycle done pulse; the memory strobes
// (o_mem_read_req / o_mem_write_valid) are one-cycle pulses answered by a
// one-cycle i_mem_read_done / i_mem_write_done of the matching kind.
module mem_arbiter #(
    parameter int DATA_WIDTH       = 64,
    parameter int ADDR_WIDTH       = 64,
    parameter int CACHE_LINE_WIDTH = 256,
    parameter int STARVE_LIMIT     = 4,
    localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_ic_read_req,
    input  logic [ADDR_WIDTH-1:0]       i_ic_read_address,
    output logic                        o_ic_read_done,
    output logic [CACHE_LINE_WIDTH-1:0] o_ic_cache_line,
    input  logic                        i_dc_read_req,
    input  logic [ADDR_WIDTH-1:0]       i_dc_read_address,
    output logic                        o_dc_read_done,
    output logic [CACHE_LINE_WIDTH-1:0] o_dc_cache_line,
    input  logic                        i_dc_write_valid,
    input  logic [ADDR_WIDTH-1:0]       i_dc_write_address,
    input  logic [DATA_WIDTH-1:0]       i_dc_write_data,
    input  logic [7:0]                  i_dc_write_strobe,
    output logic                        o_dc_write_done,
    output logic                        o_mem_read_req,
    output logic [ADDR_WIDTH-1:0]       o_mem_read_address,
    input  logic                        i_mem_read_done,
    input  logic [CACHE_LINE_WIDTH-1:0] i_cache_line,
    output logic                        o_mem_write_valid,
    output logic [ADDR_WIDTH-1:0]       o_mem_write_address,
    output logic [DATA_WIDTH-1:0]       o_mem_write_data,
    output logic [7:0]                  o_write_strobe,
    input  logic                        i_mem_write_done,
    output logic                        o_busy,
    output logic [1:0]                  o_dbg_state,
    output logic [CNT_W-1:0]            o_dbg_stall_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_IC    = 2'd1,
        REQ_DC_RD = 2'd2,
        REQ_DC_WR = 2'd3
    } req_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t                      state_q, state_d;
    req_t                        gnt_q, gnt_d;
    req_t                        grant;
    logic                        starve;
    logic [CNT_W-1:0]            stall_cnt_q, stall_cnt_d;
    logic [ADDR_WIDTH-1:0]       rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0]       wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]       wr_data_q, wr_data_d;
    logic [7:0]                  wr_strb_q, wr_strb_d;
    logic [CACHE_LINE_WIDTH-1:0] ic_line_q, ic_line_d;
    logic [CACHE_LINE_WIDTH-1:0] dc_line_q, dc_line_d;

    // Line-offset bits of the refill addresses are dropped by alignment.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_ic_read_address[4:0], i_dc_read_address[4:0]};

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= REQ_NONE;
            stall_cnt_q <= '0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_strb_q   <= '0;
            ic_line_q   <= '0;
            dc_line_q   <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            stall_cnt_q <= stall_cnt_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_strb_q   <= wr_strb_d;
            ic_line_q   <= ic_line_d;
            dc_line_q   <= dc_line_d;
        end
    end

    // Arbitration in IDLE, sequencing ISSUE -> WAIT -> RESP, refill capture.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        stall_cnt_d = stall_cnt_q;
        rd_addr_d   = rd_addr_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_strb_d   = wr_strb_q;
        ic_line_d   = ic_line_q;
        dc_line_d   = dc_line_q;
        grant       = REQ_NONE;
        starve      = i_ic_read_req && (stall_cnt_q == LIMIT);

        case (state_q)
            ST_IDLE: begin
                // The starvation override beats the fixed D-store > D-refill > I-refill order.
                if (starve)                grant = REQ_IC;
                else if (i_dc_write_valid) grant = REQ_DC_WR;
                else if (i_dc_read_req)    grant = REQ_DC_RD;
                else if (i_ic_read_req)    grant = REQ_IC;

                // Only D-side grants that bypass a waiting I-refill count.
                if (!i_ic_read_req || grant == REQ_IC) begin
                    stall_cnt_d = '0;
                end else if (grant != REQ_NONE) begin
                    stall_cnt_d = stall_cnt_q + CNT_W'(1);
                end

                if (grant != REQ_NONE) begin
                    state_d = ST_ISSUE;
                    gnt_d   = grant;
                end

                case (grant)
                    REQ_IC:    rd_addr_d = {i_ic_read_address[ADDR_WIDTH-1:5], 5'b0};
                    REQ_DC_RD: rd_addr_d = {i_dc_read_address[ADDR_WIDTH-1:5], 5'b0};
                    REQ_DC_WR: begin
                        wr_addr_d = i_dc_write_address;
                        wr_data_d = i_dc_write_data;
                        wr_strb_d = i_dc_write_strobe;
                    end
                    default: ;
                endcase
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                // A completion of the other kind is not ours and is ignored.
                if (gnt_q == REQ_DC_WR) begin
                    if (i_mem_write_done) state_d = ST_RESP;
                end else if (i_mem_read_done) begin
                    state_d = ST_RESP;
                    if (gnt_q == REQ_IC) ic_line_d = i_cache_line;
                    else                 dc_line_d = i_cache_line;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes and done pulses decode straight from the registered state.
    assign o_mem_read_req      = (state_q == ST_ISSUE) && (gnt_q == REQ_IC || gnt_q == REQ_DC_RD);
    assign o_mem_write_valid   = (state_q == ST_ISSUE) && (gnt_q == REQ_DC_WR);
    assign o_ic_read_done      = (state_q == ST_RESP) && (gnt_q == REQ_IC);
    assign o_dc_read_done      = (state_q == ST_RESP) && (gnt_q == REQ_DC_RD);
    assign o_dc_write_done     = (state_q == ST_RESP) && (gnt_q == REQ_DC_WR);
    assign o_mem_read_address  = rd_addr_q;
    assign o_mem_write_address = wr_addr_q;
    assign o_mem_write_data    = wr_data_q;
    assign o_write_strobe      = wr_strb_q;
    assign o_ic_cache_line     = ic_line_q;
    assign o_dc_cache_line     = dc_line_q;
    assign o_busy              = (state_q != ST_IDLE);
    assign o_dbg_state         = state_q;
    assign o_dbg_stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with an expected-strobe and an
// expected-done queue; a negedge monitor pops and compares whenever the
// arbiter strobes memory or returns a completion.
module tb_mem_arbiter;

  localparam logic [1:0] K_IC  = 2'd1;
  localparam logic [1:0] K_DCR = 2'd2;
  localparam logic [1:0] K_DCW = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [31:0] cyc;
    logic [2:0]  stall;
  } strobe_exp_t;

  typedef struct packed {
    logic [1:0]   kind;
    logic [31:0]  cyc;
    logic [255:0] line;
  } done_exp_t;

  logic         clk;
  logic         i_rst;
  logic         i_ic_read_req;
  logic [63:0]  i_ic_read_address;
  logic         o_ic_read_done;
  logic [255:0] o_ic_cache_line;
  logic         i_dc_read_req;
  logic [63:0]  i_dc_read_address;
  logic         o_dc_read_done;
  logic [255:0] o_dc_cache_line;
  logic         i_dc_write_valid;
  logic [63:0]  i_dc_write_address;
  logic [63:0]  i_dc_write_data;
  logic [7:0]   i_dc_write_strobe;
  logic         o_dc_write_done;
  logic         o_mem_read_req;
  logic [63:0]  o_mem_read_address;
  logic         i_mem_read_done;
  logic [255:0] i_cache_line;
  logic         o_mem_write_valid;
  logic [63:0]  o_mem_write_address;
  logic [63:0]  o_mem_write_data;
  logic [7:0]   o_write_strobe;
  logic         i_mem_write_done;
  logic         o_busy;
  logic [1:0]   o_dbg_state;
  logic [2:0]   o_dbg_stall_cnt;

  strobe_exp_t  sq[$];
  done_exp_t    dq[$];
  int           vectors = 0;
  int           miscompares = 0;
  int           cyc = 0;
  int           mem_lat = 1;
  int           inject_req = 0;
  logic [255:0] mdl_ic = '0;
  logic [255:0] mdl_dc = '0;

  mem_arbiter dut (
    .i_clk               (clk),
    .i_rst               (i_rst),
    .i_ic_read_req       (i_ic_read_req),
    .i_ic_read_address   (i_ic_read_address),
    .o_ic_read_done      (o_ic_read_done),
    .o_ic_cache_line     (o_ic_cache_line),
    .i_dc_read_req       (i_dc_read_req),
    .i_dc_read_address   (i_dc_read_address),
    .o_dc_read_done      (o_dc_read_done),
    .o_dc_cache_line     (o_dc_cache_line),
    .i_dc_write_valid    (i_dc_write_valid),
    .i_dc_write_address  (i_dc_write_address),
    .i_dc_write_data     (i_dc_write_data),
    .i_dc_write_strobe   (i_dc_write_strobe),
    .o_dc_write_done     (o_dc_write_done),
    .o_mem_read_req      (o_mem_read_req),
    .o_mem_read_address  (o_mem_read_address),
    .i_mem_read_done     (i_mem_read_done),
    .i_cache_line        (i_cache_line),
    .o_mem_write_valid   (o_mem_write_valid),
    .o_mem_write_address (o_mem_write_address),
    .o_mem_write_data    (o_mem_write_data),
    .o_write_strobe      (o_write_strobe),
    .i_mem_write_done    (i_mem_write_done),
    .o_busy              (o_busy),
    .o_dbg_state         (o_dbg_state),
    .o_dbg_stall_cnt     (o_dbg_stall_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line content the memory model returns for a given aligned address.
  function automatic logic [255:0] line_of(input logic [63:0] a);
    return {a ^ 64'h0123_4567_89AB_CDEF, ~a, a + 64'd1, {a[31:0], a[63:32]}};
  endfunction

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_strobe(input logic [1:0] k, input logic [63:0] a, input logic [63:0] d,
                            input logic [7:0] s, input int c, input logic [2:0] st);
    strobe_exp_t e;
    e.kind = k; e.addr = a; e.data = d; e.strb = s; e.cyc = c; e.stall = st;
    sq.push_back(e);
  endtask

  task automatic exp_done(input logic [1:0] k, input int c, input logic [255:0] l);
    done_exp_t e;
    e.kind = k; e.cyc = c; e.line = l;
    dq.push_back(e);
  endtask

  // ---------------- memory model ----------------
  initial begin
    logic        saw_rd, saw_wr, armed, arm_rd;
    logic [63:0] saw_addr, arm_addr;
    int          cnt;
    int          inject_done;
    armed = 0; arm_rd = 0; arm_addr = '0; cnt = 0; inject_done = 0;
    i_mem_read_done = 0; i_mem_write_done = 0; i_cache_line = '0;
    forever begin
      @(negedge clk);
      saw_rd = o_mem_read_req; saw_wr = o_mem_write_valid; saw_addr = o_mem_read_address;
      @(posedge clk);
      #1;
      i_mem_read_done = 0; i_mem_write_done = 0;
      if (saw_rd || saw_wr) begin
        armed = 1; cnt = mem_lat; arm_rd = saw_rd; arm_addr = saw_addr;
      end
      if (inject_req != inject_done) begin
        i_mem_read_done = 1;
        i_cache_line = {4{64'hBADB_ADBA_DBAD_BAD0}};
        inject_done++;
      end
      if (armed) begin
        if (cnt <= 1) begin
          armed = 0;
          if (arm_rd) begin i_mem_read_done = 1; i_cache_line = line_of(arm_addr); end
          else i_mem_write_done = 1;
        end else cnt--;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    strobe_exp_t se;
    done_exp_t   de;
    if (i_rst) begin mdl_ic = '0; mdl_dc = '0; end
    if (o_mem_read_req || o_mem_write_valid) begin
      check("strobe_exclusive", o_mem_read_req & o_mem_write_valid, 0);
      if (sq.size() == 0) check("unexpected_strobe", {o_mem_read_req, o_mem_write_valid}, 0);
      else begin
        se = sq.pop_front();
        check("strobe_is_write", o_mem_write_valid, se.kind == K_DCW);
        check("strobe_cycle", cyc, se.cyc);
        check("strobe_stall_cnt", o_dbg_stall_cnt, se.stall);
        if (se.kind == K_DCW)
          check("write_fields", {o_mem_write_address, o_mem_write_data, o_write_strobe},
                {se.addr, se.data, se.strb});
        else check("read_address", o_mem_read_address, se.addr);
      end
    end
    if (o_ic_read_done || o_dc_read_done || o_dc_write_done) begin
      if (dq.size() == 0)
        check("unexpected_done", {o_ic_read_done, o_dc_read_done, o_dc_write_done}, 0);
      else begin
        de = dq.pop_front();
        check("done_requester", {o_ic_read_done, o_dc_read_done, o_dc_write_done},
              {de.kind == K_IC, de.kind == K_DCR, de.kind == K_DCW});
        check("done_cycle", cyc, de.cyc);
        if (de.kind == K_IC)  mdl_ic = de.line;
        if (de.kind == K_DCR) mdl_dc = de.line;
        check("ic_cache_line", o_ic_cache_line, mdl_ic);
        check("dc_cache_line", o_dc_cache_line, mdl_dc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_ic(input logic [63:0] a);
    logic seen;
    seen = 0;
    i_ic_read_address = a; i_ic_read_req = 1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (o_ic_read_done) begin seen = 1; break; end
    end
    check("ic_done_seen", seen, 1);
    @(posedge clk); #1; i_ic_read_req = 0;
  endtask

  task automatic drive_dcr(input logic [63:0] a);
    logic seen;
    seen = 0;
    i_dc_read_address = a; i_dc_read_req = 1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (o_dc_read_done) begin seen = 1; break; end
    end
    check("dcr_done_seen", seen, 1);
    @(posedge clk); #1; i_dc_read_req = 0;
  endtask

  task automatic drive_dcw(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    logic seen;
    seen = 0;
    i_dc_write_address = a; i_dc_write_data = d; i_dc_write_strobe = s; i_dc_write_valid = 1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (o_dc_write_done) begin seen = 1; break; end
    end
    check("dcw_done_seen", seen, 1);
    @(posedge clk); #1; i_dc_write_valid = 0;
  endtask

  task automatic pulse_reset();
    i_rst = 1;
    repeat (2) @(posedge clk);
    #1; i_rst = 0;
  endtask

  function automatic logic [11:0] outs_nonzero();
    return {o_ic_read_done, |o_ic_cache_line, o_dc_read_done, |o_dc_cache_line, o_dc_write_done,
            o_mem_read_req, |o_mem_read_address, o_mem_write_valid, |o_mem_write_address,
            |o_mem_write_data, |o_write_strobe, o_busy};
  endfunction

  // ---------------- directed stimulus ----------------
  initial begin
    int c;
    i_rst = 1;
    i_ic_read_req = 0; i_ic_read_address = '0;
    i_dc_read_req = 0; i_dc_read_address = '0;
    i_dc_write_valid = 0; i_dc_write_address = '0; i_dc_write_data = '0; i_dc_write_strobe = '0;

    // Reset held 2 cycles with every request high; store wins first.
    fork
      drive_dcw(64'hA000_0010, 64'hDEAD_BEEF_0BAD_F00D, 8'h81);
      drive_dcr(64'hB000_0025);
      drive_ic(64'hC000_003F);
      begin
        repeat (2) begin
          @(posedge clk); #1;
          check("reset_outputs", outs_nonzero(), 0);
          check("reset_state", {o_dbg_state, o_dbg_stall_cnt}, 0);
        end
        i_rst = 0; c = cyc;
        exp_strobe(K_DCW, 64'hA000_0010, 64'hDEAD_BEEF_0BAD_F00D, 8'h81, c + 1, 3'd1);
        exp_done(K_DCW, c + 3, '0);
        exp_strobe(K_DCR, 64'hB000_0020, '0, '0, c + 5, 3'd2);
        exp_done(K_DCR, c + 7, line_of(64'hB000_0020));
        exp_strobe(K_IC, 64'hC000_0020, '0, '0, c + 9, 3'd0);
        exp_done(K_IC, c + 11, line_of(64'hC000_0020));
      end
    join

    // Single I-refill from a clean reset; D line stays zero.
    pulse_reset();
    repeat (2) @(posedge clk); #1;
    c = cyc;
    exp_strobe(K_IC, 64'h40, '0, '0, c + 1, 3'd0);
    exp_done(K_IC, c + 3, line_of(64'h40));
    drive_ic(64'h48);

    // Simultaneous D-store and D-refill: store first, refill 4 cycles later.
    repeat (2) @(posedge clk); #1;
    c = cyc;
    exp_strobe(K_DCW, 64'h1000_0008, 64'h1122_3344_5566_7788, 8'h0F, c + 1, 3'd0);
    exp_done(K_DCW, c + 3, '0);
    exp_strobe(K_DCR, 64'h2000_0020, '0, '0, c + 5, 3'd0);
    exp_done(K_DCR, c + 7, line_of(64'h2000_0020));
    fork
      drive_dcw(64'h1000_0008, 64'h1122_3344_5566_7788, 8'h0F);
      drive_dcr(64'h2000_0033);
    join

    // Starvation: 4 D grants while the I-refill waits, then the I-refill.
    repeat (2) @(posedge clk); #1;
    c = cyc;
    exp_strobe(K_DCW, 64'h100, 64'h1, 8'h01, c + 1, 3'd1);  exp_done(K_DCW, c + 3, '0);
    exp_strobe(K_DCR, 64'h200, '0, '0, c + 5, 3'd2);        exp_done(K_DCR, c + 7, line_of(64'h200));
    exp_strobe(K_DCW, 64'h310, 64'h3, 8'h03, c + 9, 3'd3);  exp_done(K_DCW, c + 11, '0);
    exp_strobe(K_DCR, 64'h400, '0, '0, c + 13, 3'd4);       exp_done(K_DCR, c + 15, line_of(64'h400));
    exp_strobe(K_IC, 64'h3000_0000, '0, '0, c + 17, 3'd0);  exp_done(K_IC, c + 19, line_of(64'h3000_0000));
    exp_strobe(K_DCW, 64'h500, 64'h5, 8'h05, c + 21, 3'd0); exp_done(K_DCW, c + 23, '0);
    fork
      drive_ic(64'h3000_001F);
      begin
        drive_dcw(64'h100, 64'h1, 8'h01);
        drive_dcr(64'h208);
        drive_dcw(64'h310, 64'h3, 8'h03);
        drive_dcr(64'h41F);
        drive_dcw(64'h500, 64'h5, 8'h05);
      end
    join

    // Slow memory (5 cycles): FSM parks in WAIT, no second strobe.
    repeat (2) @(posedge clk); #1;
    mem_lat = 5; c = cyc;
    exp_strobe(K_DCR, 64'h5000_0040, '0, '0, c + 1, 3'd0);
    exp_done(K_DCR, c + 7, line_of(64'h5000_0040));
    fork
      drive_dcr(64'h5000_0047);
      begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("wait_hold", o_dbg_state, 2'd2);
        end
      end
    join

    // Store with a stray read completion during WAIT.
    repeat (2) @(posedge clk); #1;
    mem_lat = 3; c = cyc;
    exp_strobe(K_DCW, 64'h7000_0008, 64'hCAFE_F00D_1234_5678, 8'h3C, c + 1, 3'd0);
    exp_done(K_DCW, c + 5, '0);
    fork
      drive_dcw(64'h7000_0008, 64'hCAFE_F00D_1234_5678, 8'h3C);
      begin
        repeat (2) @(negedge clk);
        inject_req++;
      end
    join

    // Reset during WAIT, then a late read completion: nothing returned.
    repeat (2) @(posedge clk); #1;
    mem_lat = 5; c = cyc;
    exp_strobe(K_IC, 64'h6000_0060, '0, '0, c + 1, 3'd0);
    i_ic_read_address = 64'h6000_0077; i_ic_read_req = 1;
    repeat (2) @(posedge clk); #1;
    i_rst = 1; i_ic_read_req = 0;
    @(posedge clk); #1;
    i_rst = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("post_reset_idle", {o_dbg_state, o_busy, o_ic_read_done, o_dc_read_done,
                                o_dc_write_done, |o_ic_cache_line}, 0);
    end

    // Drain and report.
    for (int k = 0; k < 50; k++) begin
      if (sq.size() == 0 && dq.size() == 0) break;
      @(negedge clk);
    end
    check("queues_drained", sq.size() + dq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer in front of the single-port main memory. It shares the memory read channel (256-bit line refill) and write channel (64-bit strobed store) between three requesters: I-cache refill, D-cache refill and D-cache store. It issues exactly one single-cycle memory strobe per transaction and returns the completion to the winning requester. It sits between the L1 caches and main memory.

## Interface
- DATA_WIDTH, 64, store data width
- ADDR_WIDTH, 64, address width
- CACHE_LINE_WIDTH, 256, refill line width
- STARVE_LIMIT, 4, consecutive D-side grants allowed while an I-cache refill is pending
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_ic_read_req  in  1  I-cache refill request, level, held until o_ic_read_done
- i_ic_read_address  in  ADDR_WIDTH  I-cache refill address
- o_ic_read_done  out  1  one-cycle completion pulse
- o_ic_cache_line  out  CACHE_LINE_WIDTH  refill data, valid while o_ic_read_done=1, held afterwards
- i_dc_read_req / i_dc_read_address / o_dc_read_done / o_dc_cache_line  same as I-cache, for the D-cache
- i_dc_write_valid  in  1  D-cache store request, level, held until o_dc_write_done
- i_dc_write_address  in  ADDR_WIDTH  store address
- i_dc_write_data  in  DATA_WIDTH  store data
- i_dc_write_strobe  in  8  byte enables
- o_dc_write_done  out  1  one-cycle completion pulse
- o_mem_read_req  out  1  memory read strobe
- o_mem_read_address  out  ADDR_WIDTH  line-aligned read address
- i_mem_read_done  in  1  memory read completion
- i_cache_line  in  CACHE_LINE_WIDTH  memory line data, valid with i_mem_read_done
- o_mem_write_valid  out  1  memory write strobe
- o_mem_write_address, o_mem_write_data, o_write_strobe  out  ADDR_WIDTH/DATA_WIDTH/8  registered store fields
- i_mem_write_done  in  1  memory write completion
- o_busy  out  1  high in every state except IDLE

## Operation
- FSM states:
  - IDLE → ISSUE on grant.
  - ISSUE → WAIT unconditionally.
  - WAIT → RESP when the completion matching the granted kind arrives. A read waits for i_mem_read_done; a write waits for i_mem_write_done.
  - RESP → IDLE.
- Grant is evaluated only in IDLE. Priority is D-store > D-refill > I-refill.
- Starvation override: a 3-bit-or-wider counter stall_cnt is used.
  - It increments on each D-side grant made while i_ic_read_req=1.
  - It clears on an I-refill grant, or whenever i_ic_read_req=0 in IDLE.
  - When stall_cnt==STARVE_LIMIT and i_ic_read_req=1, the I-refill wins over both D requests.
- At grant, latch the requester ID and the memory fields:
  - Read address: {addr[ADDR_WIDTH-1:5], 5'b0}.
  - Write address, data and strobe: passed unchanged.
- ISSUE: o_mem_read_req or o_mem_write_valid is high for exactly this one cycle. The two are never high together.
- WAIT: capture i_cache_line into the granted requester's line register on i_mem_read_done. The other requester's line register is untouched.
- RESP: the granted requester's done is high for exactly one cycle. Request inputs are ignored in this state, so a request still held during done is not re-granted.
- Memory done pulses seen in IDLE, ISSUE or RESP are ignored. So is a done of the wrong kind in WAIT.
- No ordering is guaranteed between a pending D-store and an I-refill granted by the override. Fences are handled upstream.

## Timing
- Reset: state=IDLE, stall_cnt=0, and all outputs are 0. This includes line registers, o_busy and both memory strobes.
- Reset mid-transaction aborts it. No done is returned, and a late memory done after reset is ignored.
- With a 1-cycle memory, a request sampled in IDLE at edge E0 gives:
  - strobe high E0–E1
  - memory done E1–E2
  - requester done high E2–E3
  - earliest next grant sampled at E4
- Throughput is one transaction per 4 cycles.
- Slower memory extends WAIT by the extra cycles.
- Requests that arrive during non-IDLE states wait. Nothing is dropped, because requests are levels.

## Test plan
- Reset: hold i_rst 2 cycles with all requests high → all outputs 0, no strobe; first strobe is o_mem_write_valid in the cycle after the edge where i_rst=0 is sampled.
- Single I-refill at address 0x48 → o_mem_read_address=0x40 for one cycle, o_ic_read_done 2 cycles after grant edge, o_ic_cache_line equals the memory line, o_dc_cache_line stays 0.
- Simultaneous D-store (strobe 8'h0F, data 64'h1122334455667788) and D-refill → store is granted first with fields passed unchanged, and the refill is granted 4 cycles later.
- Starvation: hold i_ic_read_req and alternate D requests continuously → exactly 4 D grants, then an I grant; counter restarts at 0 after it.
- Delayed memory: return done 5 cycles after strobe → FSM holds in WAIT, strobe is not re-asserted, and done returns to the correct requester.
- Reset during WAIT, then a late i_mem_read_done → no requester done, FSM in IDLE.
